// File: rtl/segway_pkg.sv
// -----------------------------------------------------------------------------
// segway_pkg
// Shared definitions for the Segway rider-authorization front end.
//   CMD_GO / CMD_STOP : command byte values decoded by the auth FSM
//   rx_state_t        : UART receiver state encoding
//   auth_state_t      : power-up authorization state encoding
// -----------------------------------------------------------------------------
package segway_pkg;

    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'
    localparam logic [7:0] CMD_STOP = 8'h53;  // 'S'

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        PWR1 = 2'd1,
        PWR2 = 2'd2
    } auth_state_t;

endpackage

// File: rtl/seg_uart_rx.sv
// -----------------------------------------------------------------------------
// seg_uart_rx
// 8N1 UART receiver. RX is synchronized (2 flops) plus one edge-detect flop,
// all resetting to 1. A start edge is honoured only in IDLE and only once the
// line has been seen idle high for a full frame time after reset, so a frame
// already in flight when reset releases is never decoded.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   RX        in   asynchronous serial input, idle high
//   rx_data   out  [7:0] last byte received with a good stop bit
//   cmd_vld   out  one-cycle pulse, byte complete with stop bit = 1
//   frame_err out  one-cycle pulse, stop bit sampled 0
//
// Output protocol: cmd_vld is a strobe with no back-pressure. rx_data is
// already updated in the cycle cmd_vld is high and holds until the next good
// byte. cmd_vld and frame_err are mutually exclusive and never high on two
// consecutive cycles.
// -----------------------------------------------------------------------------
module seg_uart_rx
    import segway_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       cmd_vld,
    output logic       frame_err
);

    localparam int CW      = $clog2(BAUD_DIV + 1);
    localparam int ARM_CYC = 10 * BAUD_DIV;
    localparam int AW      = $clog2(ARM_CYC + 1);

    // Synchronizer and edge-detect flops
    logic rx_ff1, rx_ff2, rx_ff3;
    logic fall;

    // Receiver state
    rx_state_t      rx_state, rx_nxt;
    logic [CW-1:0]  baud_cnt, baud_nxt;
    logic [2:0]     bit_cnt, bit_nxt;
    logic [7:0]     shift, shift_nxt;
    logic [7:0]     data_nxt;
    logic           vld_nxt, ferr_nxt;
    logic           baud_tick;

    // Line-idle qualification after reset
    logic           armed;
    logic [AW-1:0]  idle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ff1 <= 1'b1;
            rx_ff2 <= 1'b1;
            rx_ff3 <= 1'b1;
        end else begin
            rx_ff1 <= RX;
            rx_ff2 <= rx_ff1;
            rx_ff3 <= rx_ff2;
        end
    end

    assign fall = rx_ff3 & ~rx_ff2;

    // The counter counts down to 1 so a reload of N gives exactly N cycles
    // between samples.
    assign baud_tick = (baud_cnt == CW'(1));

    // Require ten bit-times of continuous high before accepting any start
    // edge; one bit of high inside a frame is not enough to prove idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed    <= 1'b0;
            idle_cnt <= '0;
        end else if (!armed) begin
            if (rx_ff2) begin
                if (idle_cnt == AW'(ARM_CYC - 1)) armed <= 1'b1;
                else                               idle_cnt <= idle_cnt + AW'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            cmd_vld   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift     <= shift_nxt;
            rx_data   <= data_nxt;
            cmd_vld   <= vld_nxt;
            frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        rx_nxt    = rx_state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        data_nxt  = rx_data;
        vld_nxt   = 1'b0;
        ferr_nxt  = 1'b0;
        case (rx_state)
            IDLE: begin
                if (armed && fall) begin
                    rx_nxt   = START;
                    baud_nxt = CW'(BAUD_DIV / 2);
                end
            end
            START: begin
                if (baud_tick) begin
                    if (rx_ff2) begin
                        rx_nxt = IDLE;          // glitch, not a start bit
                    end else begin
                        rx_nxt   = DATA;
                        baud_nxt = CW'(BAUD_DIV);
                        bit_nxt  = 3'd0;
                    end
                end else begin
                    baud_nxt = baud_cnt - CW'(1);
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_nxt = {rx_ff2, shift[7:1]};   // LSB first
                    baud_nxt  = CW'(BAUD_DIV);
                    if (bit_cnt == 3'd7) rx_nxt  = STOP;
                    else                 bit_nxt = bit_cnt + 3'd1;
                end else begin
                    baud_nxt = baud_cnt - CW'(1);
                end
            end
            STOP: begin
                if (baud_tick) begin
                    // Leave for IDLE at stop-bit centre so a back-to-back start
                    // edge half a bit later is caught.
                    rx_nxt = IDLE;
                    if (rx_ff2) begin
                        data_nxt = shift;
                        vld_nxt  = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt - CW'(1);
                end
            end
            default: rx_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/auth_rx_blk.sv
// -----------------------------------------------------------------------------
// auth_rx_blk
// Rider-authorization front end: UART command receiver feeding the power-up
// authorization FSM (OFF -> PWR1 on 'G', PWR1 -> PWR2 on 'S' with a rider,
// PWR2 -> OFF as soon as the rider steps off).
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   RX        in   asynchronous UART input, idle high
//   rider_off in   high when load cells report no rider (clk domain)
//   rx_data   out  [7:0] last good received byte
//   cmd_vld   out  one-cycle pulse per good byte
//   frame_err out  one-cycle pulse per bad stop bit
//   pwr_up    out  authorization to run (PWR1 or PWR2)
// -----------------------------------------------------------------------------
module auth_rx_blk
    import segway_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       cmd_vld,
    output logic       frame_err,
    output logic       pwr_up
);

    auth_state_t auth_state, auth_nxt;

    seg_uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .rx_data   (rx_data),
        .cmd_vld   (cmd_vld),
        .frame_err (frame_err)
    );

    // pwr_up is registered from the next state so it moves on the same edge
    // as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            auth_state <= OFF;
            pwr_up     <= 1'b0;
        end else begin
            auth_state <= auth_nxt;
            pwr_up     <= (auth_nxt != OFF);
        end
    end

    always_comb begin
        auth_nxt = auth_state;
        case (auth_state)
            OFF: begin
                if (cmd_vld && rx_data == CMD_GO) auth_nxt = PWR1;
            end
            PWR1: begin
                if (cmd_vld && rx_data == CMD_STOP)
                    auth_nxt = rider_off ? OFF : PWR2;
            end
            PWR2: begin
                // Rider leaving drops power immediately, no command needed.
                if (rider_off)                         auth_nxt = OFF;
                else if (cmd_vld && rx_data == CMD_GO) auth_nxt = PWR1;
            end
            default: auth_nxt = OFF;
        endcase
    end

endmodule

// File: tb/tb_auth_rx_blk.sv
module tb_auth_rx_blk;

    localparam int BAUD = 16;
    localparam int NOM  = 9 * BAUD + BAUD / 2 + 3;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ro;
        logic       exp_vld;
        logic       exp_ferr;
        logic [7:0] exp_rx;
        logic       exp_pwr;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rider_off;
    logic [7:0] rx_data;
    logic       cmd_vld;
    logic       frame_err;
    logic       pwr_up;

    int         checks;
    int         errors;
    int         cyc;
    int         vld_cnt;
    int         ferr_cnt;
    logic       prev_pulse;
    logic       exp_pwr_prev;
    logic [7:0] exp_q[$];
    vec_t       vecs[13];

    auth_rx_blk #(
        .BAUD_DIV (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (rx),
        .rider_off (rider_off),
        .rx_data   (rx_data),
        .cmd_vld   (cmd_vld),
        .frame_err (frame_err),
        .pwr_up    (pwr_up)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / pulse monitor ----------------
    initial prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_vld)   vld_cnt++;
            if (frame_err) ferr_cnt++;
            if (cmd_vld || frame_err) begin
                checks++;
                if ((cmd_vld && frame_err) || prev_pulse) begin
                    errors++;
                    $display("FAIL pulse_shape: vld=%0b ferr=%0b prev=%0b at cycle %0d",
                             cmd_vld, frame_err, prev_pulse, cyc);
                end
            end
            if (cmd_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got byte %0h expected no cmd_vld", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL sb_byte: got %0h expected %0h", rx_data, e);
                    end
                end
            end
            prev_pulse = cmd_vld | frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    // ---------------- driver ----------------
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input string name, input vec_t v, input int gap);
        logic [9:0] bits;
        int   nv, nf, lat, start;
        logic pend, pwr_at, pwr_nxt;
        bits = {v.stop, v.data, 1'b0};
        nv = 0; nf = 0; lat = 0; start = 0;
        pend = 1'b0; pwr_at = 1'b0; pwr_nxt = 1'b0;
        if (v.exp_vld) exp_q.push_back(v.exp_rx);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BAUD; c++) begin
                @(negedge clk);
                if (pend) begin
                    pwr_nxt = pwr_up;
                    pend    = 1'b0;
                end
                if (cmd_vld) begin
                    nv++;
                    lat    = cyc - (start + 1);
                    pwr_at = pwr_up;
                    pend   = 1'b1;
                end
                if (frame_err) nf++;
                if (b == 0 && c == 0) begin
                    start     = cyc;
                    rider_off = v.ro;
                end
                if (c == 0) rx = bits[b];
            end
        end
        rx = 1'b1;
        repeat (gap) @(negedge clk);

        check({name, "_vld_count"}, nv, {31'd0, v.exp_vld});
        check({name, "_ferr_count"}, nf, {31'd0, v.exp_ferr});
        check({name, "_rx_data"}, {24'd0, rx_data}, {24'd0, v.exp_rx});
        check({name, "_pwr_up"}, {31'd0, pwr_up}, {31'd0, v.exp_pwr});
        if (v.exp_vld && nv == 1) begin
            checks++;
            if (lat < NOM - 2 || lat > NOM + 2) begin
                errors++;
                $display("FAIL %s_latency: got %0d cycles expected %0d +/-2", name, lat, NOM);
            end
            check({name, "_pwr_at_vld"}, {31'd0, pwr_at}, {31'd0, exp_pwr_prev});
            check({name, "_pwr_next"}, {31'd0, pwr_nxt}, {31'd0, v.exp_pwr});
        end
        exp_pwr_prev = v.exp_pwr;
    endtask

    // ---------------- test ----------------
    initial begin
        int   v0, f0;
        int   h;
        vec_t g;
        logic [9:0] bits;

        checks = 0; errors = 0; vld_cnt = 0; ferr_cnt = 0;
        rst = 1'b1; rx = 1'b1; rider_off = 1'b0; exp_pwr_prev = 1'b0;

        //          data   stop  ro    vld   ferr  exp_rx  pwr
        vecs[0]  = '{8'h47, 1'b1, 1'b0, 1'b1, 1'b0, 8'h47, 1'b1}; // G: OFF->PWR1
        vecs[1]  = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1}; // other byte
        vecs[2]  = '{8'h53, 1'b1, 1'b1, 1'b1, 1'b0, 8'h53, 1'b0}; // S, no rider: ->OFF
        vecs[3]  = '{8'h47, 1'b1, 1'b0, 1'b1, 1'b0, 8'h47, 1'b1}; // G: ->PWR1
        vecs[4]  = '{8'h53, 1'b1, 1'b0, 1'b1, 1'b0, 8'h53, 1'b1}; // S, rider: ->PWR2
        vecs[5]  = '{8'h53, 1'b1, 1'b0, 1'b1, 1'b0, 8'h53, 1'b1}; // S in PWR2: none
        vecs[6]  = '{8'h47, 1'b1, 1'b0, 1'b1, 1'b0, 8'h47, 1'b1}; // G in PWR2: ->PWR1
        vecs[7]  = '{8'h47, 1'b1, 1'b0, 1'b1, 1'b0, 8'h47, 1'b1}; // G in PWR1: none
        vecs[8]  = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b1, 8'h47, 1'b1}; // bad stop
        vecs[9]  = '{8'h53, 1'b0, 1'b0, 1'b0, 1'b1, 8'h47, 1'b1}; // bad stop, S ignored
        vecs[10] = '{8'h53, 1'b1, 1'b0, 1'b1, 1'b0, 8'h53, 1'b1}; // S: ->PWR2
        vecs[11] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[12] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_pwr_up", {31'd0, pwr_up}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_cmd_vld", {31'd0, cmd_vld}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;

        // Idle line: no pulses, outputs hold reset values
        idle(12 * BAUD);
        check("idle_vld_count", vld_cnt, 0);
        check("idle_ferr_count", ferr_cnt, 0);
        check("idle_pwr_up", {31'd0, pwr_up}, 32'd0);
        check("idle_rx_data", {24'd0, rx_data}, 32'd0);

        // Table-driven frames
        for (int i = 0; i < 13; i++)
            send_frame($sformatf("vec%0d", i), vecs[i], BAUD);

        // Rider steps off in PWR2: pwr_up drops one cycle later, no byte
        @(negedge clk);
        check("ro_pwr_before", {31'd0, pwr_up}, 32'd1);
        rider_off = 1'b1;
        @(negedge clk);
        check("ro_pwr_after", {31'd0, pwr_up}, 32'd0);
        exp_pwr_prev = 1'b0;
        idle(4);
        rider_off = 1'b0;

        // Quarter-bit glitch: no pulses of any kind
        v0 = vld_cnt; f0 = ferr_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (BAUD / 4) @(negedge clk);
        idle(3 * BAUD);
        check("glitch_vld_count", vld_cnt - v0, 0);
        check("glitch_ferr_count", ferr_cnt - f0, 0);

        // Get to PWR1, then reset during bit 4 of a G frame
        g = '{8'h47, 1'b1, 1'b0, 1'b1, 1'b0, 8'h47, 1'b1};
        send_frame("pre_rst_g", g, BAUD);
        v0 = vld_cnt; f0 = ferr_cnt;
        bits = {1'b1, 8'h47, 1'b0};
        h = BAUD / 2;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BAUD; c++) begin
                @(negedge clk);
                if (b == 5 && c == h + 1) begin
                    check("midrst_pwr_up", {31'd0, pwr_up}, 32'd0);
                    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
                    rst = 1'b0;
                end
                if (c == 0) rx = bits[b];
                if (b == 5 && c == h) rst = 1'b1;
            end
        end
        exp_pwr_prev = 1'b0;
        idle(12 * BAUD);
        check("midrst_vld_count", vld_cnt - v0, 0);
        check("midrst_ferr_count", ferr_cnt - f0, 0);
        send_frame("post_rst_g", g, BAUD);

        // Back-to-back G then S, zero idle between frames
        v0 = vld_cnt;
        send_frame("b2b_g", g, 0);
        send_frame("b2b_s", '{8'h53, 1'b1, 1'b0, 1'b1, 1'b0, 8'h53, 1'b1}, BAUD);
        check("b2b_vld_count", vld_cnt - v0, 2);

        idle(BAUD);
        check("sb_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
